// File: rtl/ifetch_queue.sv
// ifetch_queue: owns the fetch PC, keeps one I-bus request in flight and queues fetched words for decode (optional macro IFQ_BYPASS_EN).
// Latency: a word appears on out_* one cycle after iresp_data_ok; with IFQ_BYPASS_EN and an empty FIFO it appears in the same cycle.
// Backpressure: out_ready low lets the DEPTH-entry FIFO fill; no request issues while it is full, so data never reaches a full FIFO.
module ifetch_queue #(
    parameter int          ADDR_W   = 64,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic               clk,
    input  logic               resetn,
    output logic               ireq_valid,
    output logic [ADDR_W-1:0]  ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         out_ex
);
    localparam int                PTR_W       = $clog2(DEPTH);
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_RST      = PC_RESET[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [1:0]        EX_NONE     = 2'd0;
    localparam logic [1:0]        EX_MISALIGN = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [1:0]         mem_ex    [DEPTH];

    logic               fifo_full, fifo_empty;
    logic               push, wr_en, pop;
    logic [ADDR_W-1:0]  push_pc;
    logic [INSTR_W-1:0] push_instr;
    logic [1:0]         push_ex;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // The address is latched when a request starts so DRAIN can keep it stable while pc already holds the redirect target.
    assign ireq_valid = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign ireq_addr  = ireq_valid ? req_addr_q : '0;

    // Fetch FSM: redirect wins over everything; otherwise issue, complete, halt on misalignment or drain a stale response.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        push_pc    = pc_q;
        push_instr = '0;
        push_ex    = EX_NONE;
        if (redirect_valid) begin
            pc_d = redirect_pc;
            case (state_q)
                // A response landing with the redirect is stale and simply dropped.
                S_REQ:   state_d = iresp_data_ok ? S_IDLE : S_DRAIN;
                // The outstanding response must still be absorbed before a new request may go out.
                S_DRAIN: state_d = iresp_data_ok ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pc_q[1:0] != 2'b00) begin
                        if (!fifo_full) begin
                            push    = 1'b1;
                            push_ex = EX_MISALIGN;
                            state_d = S_HALT;
                        end
                    end else if (!fifo_full) begin
                        // Only pushes from REQ can raise count, so a free slot now is still free when the word lands.
                        state_d    = S_REQ;
                        req_addr_d = pc_q;
                    end
                end
                S_REQ: begin
                    if (iresp_data_ok) begin
                        push       = 1'b1;
                        push_pc    = req_addr_q;
                        push_instr = iresp_data;
                        pc_d       = pc_q + ADDR_W'(4);
                        state_d    = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (iresp_data_ok) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Head presentation and FIFO write/pop enables; the bypass path shortcuts an empty FIFO.
    always_comb begin
        out_valid = !fifo_empty;
        out_pc    = fifo_empty ? '0 : mem_pc[rd_ptr_q];
        out_instr = fifo_empty ? '0 : mem_instr[rd_ptr_q];
        out_ex    = fifo_empty ? 2'd0 : mem_ex[rd_ptr_q];
        pop       = !fifo_empty && out_ready;
        wr_en     = push;
`ifdef IFQ_BYPASS_EN
        // Only a truly empty FIFO bypasses: a head popping this cycle already owns out_*, so the new word queues behind it.
        if (push && fifo_empty) begin
            out_valid = 1'b1;
            out_pc    = push_pc;
            out_instr = push_instr;
            out_ex    = push_ex;
            wr_en     = !out_ready;
        end
`endif
    end

    // FIFO pointer/count next state; redirect empties the queue on the same edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // State, PC and FIFO control registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are masked on the outputs while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]    <= push_pc;
            mem_instr[wr_ptr_q] <= push_instr;
            mem_ex[wr_ptr_q]    <= push_ex;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with default parameters (DEPTH=4, PC_RESET=0x80000000).
// Drives inputs 1 time unit after the rising edge and samples outputs before the next one.
// Every scenario task carries its own hand-computed expectations.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  out_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ex         (out_ex)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (ireq_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        checks++;
        if (ireq_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_timeout: ireq_valid=%b after %0d cycles, want 1", name, ireq_valid, k);
        end
    endtask

    // Waits for a request, checks its address, answers after lat idle cycles with 0x13.
    task automatic serve(input string name, input int lat, input logic [63:0] addr);
        wait_req(name);
        checks++;
        if (ireq_addr !== addr) begin
            errors++;
            $display("FAIL %s_addr: got %h want %h", name, ireq_addr, addr);
        end
        repeat (lat) step();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        step();
        iresp_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1; iresp_data_ok = 1'b0; iresp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        #2 resetn = 1'b0;
        step(); step();
        checks += 6;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL rst_ireq_valid: got %b want 0", ireq_valid); end
        if (ireq_addr !== 64'h0) begin errors++; $display("FAIL rst_ireq_addr: got %h want 0", ireq_addr); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_pc !== 64'h0)    begin errors++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr: got %h want 0", out_instr); end
        if (out_ex !== 2'd0)     begin errors++; $display("FAIL rst_out_ex: got %0d want 0", out_ex); end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp = 64'h8000_0000 + 64'(4 * i);
            serve("basic", 1, exp);
            checks += 5;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid%0d: got %b want 1", i, out_valid); end
            if (out_pc !== exp) begin errors++; $display("FAIL basic_out_pc%0d: got %h want %h", i, out_pc, exp); end
            if (out_instr !== 32'h13) begin errors++; $display("FAIL basic_out_instr%0d: got %h want 13", i, out_instr); end
            if (out_ex !== 2'd0) begin errors++; $display("FAIL basic_out_ex%0d: got %0d want 0", i, out_ex); end
            if (ireq_valid !== 1'b0) begin errors++; $display("FAIL basic_idle%0d: ireq_valid=%b want 0", i, ireq_valid); end
        end
    endtask

    task automatic test_full();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) serve("full", 0, 64'h8000_000C + 64'(4 * i));
        repeat (4) step();
        checks += 3;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL full_no_req: ireq_valid=%b want 0", ireq_valid); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
        if (out_pc !== 64'h8000_000C) begin errors++; $display("FAIL full_head: got %h want 8000000c", out_pc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        serve("full_refill", 0, 64'h8000_001C);
        repeat (4) step();
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL full_no_req2: ireq_valid=%b want 0", ireq_valid); end
        if (out_pc !== 64'h8000_0010) begin errors++; $display("FAIL full_head2: got %h want 80000010", out_pc); end
    endtask

    // Streams from a full FIFO with a 2-of-3 ready pattern so pushes and pops overlap and pointers wrap.
    task automatic test_wrap();
        logic [63:0] exp_pc = 64'h8000_0010;
        int pops = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready     = (i % 3) != 0;
            iresp_data_ok = ireq_valid;
            iresp_data    = 32'h0000_0013;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== 32'h13) begin
                    errors++;
                    $display("FAIL wrap_order%0d: got pc %h instr %h want pc %h instr 13", pops, out_pc, out_instr, exp_pc);
                end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            step();
        end
        checks++;
        if (pops < 10) begin errors++; $display("FAIL wrap_pops: got %0d want >=10", pops); end
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iresp_data_ok = ireq_valid;
            step();
        end
        iresp_data_ok = 1'b0;
        #1;
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL wrap_full_no_req: ireq_valid=%b want 0", ireq_valid); end
        if (out_pc !== exp_pc) begin errors++; $display("FAIL wrap_head: got %h want %h", out_pc, exp_pc); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_flush: out_valid=%b want 0", out_valid); end
        step();
        checks += 5;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_out_valid: got %b want 1", out_valid); end
        if (out_pc !== 64'h8000_1002) begin errors++; $display("FAIL mis_out_pc: got %h want 80001002", out_pc); end
        if (out_instr !== 32'h0) begin errors++; $display("FAIL mis_out_instr: got %h want 0", out_instr); end
        if (out_ex !== 2'd1) begin errors++; $display("FAIL mis_out_ex: got %0d want 1", out_ex); end
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: ireq_valid=%b want 0", ireq_valid); end
        repeat (5) step();
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_halt_req: ireq_valid=%b want 0", ireq_valid); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_halt_single: out_valid=%b want 1", out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL mis_halt_req2: ireq_valid=%b want 0", ireq_valid); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mis_one_entry: out_valid=%b want 0", out_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        serve("resume", 0, 64'h8000_2000);
        checks += 2;
        if (out_pc !== 64'h8000_2000) begin errors++; $display("FAIL resume_out_pc: got %h want 80002000", out_pc); end
        if (out_ex !== 2'd0) begin errors++; $display("FAIL resume_out_ex: got %0d want 0", out_ex); end
    endtask

    task automatic test_drain();
        wait_req("drain");
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        step();
        redirect_valid = 1'b0;
        checks += 3;
        if (ireq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b want 1", ireq_valid); end
        if (ireq_addr !== 64'h8000_2004) begin errors++; $display("FAIL drain_addr: got %h want 80002004", ireq_addr); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_flush: out_valid=%b want 0", out_valid); end
        step(); step();
        checks++;
        if (ireq_addr !== 64'h8000_2004) begin errors++; $display("FAIL drain_addr_hold: got %h want 80002004", ireq_addr); end
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        step();
        iresp_data_ok = 1'b0;
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL drain_done: ireq_valid=%b want 0", ireq_valid); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: out_valid=%b want 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_discard2: out_valid=%b want 0", out_valid); end
        serve("after_drain", 0, 64'h8000_3000);
        checks += 2;
        if (out_pc !== 64'h8000_3000) begin errors++; $display("FAIL after_drain_pc: got %h want 80003000", out_pc); end
        if (out_instr !== 32'h13) begin errors++; $display("FAIL after_drain_instr: got %h want 13", out_instr); end
        // Redirect landing together with the response: data dropped, no drain.
        wait_req("redir_ok");
        redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
        iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
        step();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        checks += 2;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL redir_ok_idle: ireq_valid=%b want 0", ireq_valid); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_ok_discard: out_valid=%b want 0", out_valid); end
        out_ready = 1'b0;
        serve("after_redir_ok", 0, 64'h8000_4000);
        checks++;
        if (out_pc !== 64'h8000_4000) begin errors++; $display("FAIL after_redir_ok_pc: got %h want 80004000", out_pc); end
    endtask

    task automatic test_reset_mid();
        wait_req("rst_mid");
        resetn = 1'b0;
        #1;
        checks += 3;
        if (ireq_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_req: ireq_valid=%b want 0", ireq_valid); end
        if (ireq_addr !== 64'h0) begin errors++; $display("FAIL rst_mid_addr: got %h want 0", ireq_addr); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out: out_valid=%b want 0", out_valid); end
        step(); step();
        resetn = 1'b1;
        serve("rst_restart", 0, 64'h8000_0000);
        checks++;
        if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL rst_restart_pc: got %h want 80000000", out_pc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_misaligned();
        test_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
